hbmc_rwds_word_packer: RTL and testbench

Read-data word packer in the RWDS capture domain (clk_din), directly upstream of the read-path elastic buffer. It classifies each captured DDR beat pair (dq/rwds rise and fall samples) and handles both RWDS phase alignments. It packs bytes into 16-bit HyperBus words with valid and last flags, and presents an 18-bit frame every clk_din cycle to the elastic buffer's din, which is instantiated with DATA_WIDTH = 18. It also reports burst word count and RWDS phase-slip errors.

---
 rtl/hbmc_rwds_word_packer.sv | 129 ++++++++++++
 tb/tb_hbmc_rwds_word_packer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/hbmc_rwds_word_packer.sv
// Read-data word packer for the RWDS capture domain. It turns DDR beat pairs into
// 16-bit HyperBus words framed as {last, valid, data}. It also reports burst length and phase slips.
module hbmc_rwds_word_packer #(
  parameter int CNT_W = 10
) (
  input  logic             clk_din,
  input  logic             rst_0,
  input  logic             cap_en,
  input  logic [7:0]       dq_rise,
  input  logic [7:0]       dq_fall,
  input  logic             rwds_rise,
  input  logic             rwds_fall,
  output logic [17:0]      dout,
  output logic [CNT_W-1:0] burst_words,
  output logic             burst_done,
  output logic             slip_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ALN  = 2'd1,
    SHF  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic             stg_v, stg_v_nxt;
  logic             stg_last, stg_last_nxt;
  logic [15:0]      stg_data, stg_data_nxt;
  logic [7:0]       hold, hold_nxt;
  logic [CNT_W-1:0] wcnt, wcnt_inc;
  logic             beat_a, beat_s;
  logic             term, slip_set, push_last;

  assign beat_a    = cap_en & rwds_rise & ~rwds_fall;
  assign beat_s    = cap_en & ~rwds_rise & rwds_fall;
  assign push_last = stg_last | term;
  assign wcnt_inc  = (wcnt == CNT_MAX) ? CNT_MAX : (wcnt + CNT_ONE);

  // The stage is valid for exactly one edge unless reloaded, so every staged word is pushed once.
  always_comb begin
    state_nxt    = state;
    stg_v_nxt    = 1'b0;
    stg_last_nxt = 1'b0;
    stg_data_nxt = 16'h0;
    hold_nxt     = hold;
    term         = 1'b0;
    slip_set     = 1'b0;
    case (state)
      IDLE: begin
        if (beat_a) begin
          stg_v_nxt    = 1'b1;
          stg_data_nxt = {dq_rise, dq_fall};
          state_nxt    = ALN;
        end else if (beat_s) begin
          hold_nxt  = dq_fall;
          state_nxt = SHF;
        end
      end
      ALN: begin
        if (beat_a) begin
          stg_v_nxt    = 1'b1;
          stg_data_nxt = {dq_rise, dq_fall};
        end else begin
          term      = 1'b1;
          slip_set  = beat_s;
          state_nxt = IDLE;
        end
      end
      SHF: begin
        if (beat_s) begin
          stg_v_nxt    = 1'b1;
          stg_data_nxt = {hold, dq_rise};
          hold_nxt     = dq_fall;
        end else if (beat_a) begin
          slip_set  = 1'b1;
          term      = 1'b1;
          hold_nxt  = 8'h0;
          state_nxt = IDLE;
        end else begin
          // The closing rising-edge byte is still valid, so it completes the final word.
          stg_v_nxt    = 1'b1;
          stg_last_nxt = 1'b1;
          stg_data_nxt = {hold, dq_rise};
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_din or posedge rst_0) begin
    if (rst_0) begin
      state       <= IDLE;
      stg_v       <= 1'b0;
      stg_last    <= 1'b0;
      stg_data    <= 16'h0;
      hold        <= 8'h0;
      wcnt        <= '0;
      dout        <= 18'h0;
      burst_words <= '0;
      burst_done  <= 1'b0;
      slip_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      stg_v      <= stg_v_nxt;
      stg_last   <= stg_last_nxt;
      stg_data   <= stg_data_nxt;
      hold       <= hold_nxt;
      slip_err   <= slip_err | slip_set;
      burst_done <= 1'b0;
      if (stg_v) begin
        dout <= {push_last, 1'b1, stg_data};
        if (push_last) begin
          burst_words <= wcnt_inc;
          burst_done  <= 1'b1;
          wcnt        <= '0;
        end else begin
          wcnt <= wcnt_inc;
        end
      end else begin
        dout <= 18'h0;
      end
    end
  end

endmodule

// File: tb/tb_hbmc_rwds_word_packer.sv
// Directed bench for hbmc_rwds_word_packer. A default-width and a 4-bit-counter
// instance share the same stimulus, so counter saturation is exercised alongside normal behaviour.
module tb_hbmc_rwds_word_packer;

  logic        clk_din = 1'b0;
  logic        rst_0;
  logic        cap_en;
  logic [7:0]  dq_rise, dq_fall;
  logic        rwds_rise, rwds_fall;
  logic [17:0] dout, dout_sat;
  logic [9:0]  burst_words;
  logic [3:0]  burst_words_sat;
  logic        burst_done, burst_done_sat;
  logic        slip_err, slip_err_sat;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk_din = ~clk_din;

  hbmc_rwds_word_packer #(.CNT_W(10)) u_dut (
    .clk_din(clk_din), .rst_0(rst_0), .cap_en(cap_en),
    .dq_rise(dq_rise), .dq_fall(dq_fall),
    .rwds_rise(rwds_rise), .rwds_fall(rwds_fall),
    .dout(dout), .burst_words(burst_words),
    .burst_done(burst_done), .slip_err(slip_err)
  );

  hbmc_rwds_word_packer #(.CNT_W(4)) u_sat (
    .clk_din(clk_din), .rst_0(rst_0), .cap_en(cap_en),
    .dq_rise(dq_rise), .dq_fall(dq_fall),
    .rwds_rise(rwds_rise), .rwds_fall(rwds_fall),
    .dout(dout_sat), .burst_words(burst_words_sat),
    .burst_done(burst_done_sat), .slip_err(slip_err_sat)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one beat pair, let the next rising edge capture it, then settle for sampling.
  task automatic applyStimulus(input logic en, input logic rr, input logic rf,
                               input logic [7:0] dr, input logic [7:0] df);
    cap_en    = en;
    rwds_rise = rr;
    rwds_fall = rf;
    dq_rise   = dr;
    dq_fall   = df;
    @(posedge clk_din);
    #1;
  endtask

  task automatic beatA(input logic [7:0] dr, input logic [7:0] df);
    applyStimulus(1'b1, 1'b1, 1'b0, dr, df);
  endtask

  task automatic beatS(input logic [7:0] dr, input logic [7:0] df);
    applyStimulus(1'b1, 1'b0, 1'b1, dr, df);
  endtask

  task automatic beatN(input logic [7:0] dr);
    applyStimulus(1'b1, 1'b0, 1'b0, dr, 8'h00);
  endtask

  task automatic expectFrame(input string tag, input logic [17:0] exp_dout, input logic exp_done);
    checkOutput({tag, "_dout"}, {14'h0, dout}, {14'h0, exp_dout});
    checkOutput({tag, "_done"}, {31'h0, burst_done}, {31'h0, exp_done});
  endtask

  initial begin
    logic [7:0] b;
    rst_0 = 1'b1;
    cap_en = 1'b0; rwds_rise = 1'b0; rwds_fall = 1'b0; dq_rise = 8'h0; dq_fall = 8'h0;
    #1;
    checkOutput("rst_dout", {14'h0, dout}, 32'h0);
    checkOutput("rst_words", {22'h0, burst_words}, 32'h0);
    checkOutput("rst_done", {31'h0, burst_done}, 32'h0);
    checkOutput("rst_slip", {31'h0, slip_err}, 32'h0);
    @(posedge clk_din); #1;
    rst_0 = 1'b0;
    $display("[TB] reset released");

    // Reset mid-burst: partial words are discarded and no last frame appears.
    beatA(8'h01, 8'h02); expectFrame("rmid_b0", 18'h00000, 1'b0);
    beatA(8'h03, 8'h04); expectFrame("rmid_b1", 18'h10102, 1'b0);
    rst_0 = 1'b1;
    #1;
    checkOutput("rmid_async_dout", {14'h0, dout}, 32'h0);
    checkOutput("rmid_words", {22'h0, burst_words}, 32'h0);
    @(posedge clk_din); #1;
    rst_0 = 1'b0;
    beatN(8'h00); expectFrame("rmid_after0", 18'h00000, 1'b0);
    beatN(8'h00); expectFrame("rmid_after1", 18'h00000, 1'b0);
    checkOutput("rmid_words_after", {22'h0, burst_words}, 32'h0);

    // Aligned burst of four words.
    beatA(8'h01, 8'h02); expectFrame("aln_0", 18'h00000, 1'b0);
    beatA(8'h03, 8'h04); expectFrame("aln_1", 18'h10102, 1'b0);
    beatA(8'h05, 8'h06); expectFrame("aln_2", 18'h10304, 1'b0);
    beatA(8'h07, 8'h08); expectFrame("aln_3", 18'h10506, 1'b0);
    beatN(8'h00);        expectFrame("aln_4", 18'h30708, 1'b1);
    checkOutput("aln_words", {22'h0, burst_words}, 32'd4);
    beatN(8'h00);        expectFrame("aln_5", 18'h00000, 1'b0);

    // Shifted burst, with an aligned burst starting on the terminating edge.
    beatS(8'h00, 8'hAA); expectFrame("shf_0", 18'h00000, 1'b0);
    beatS(8'hBB, 8'hCC); expectFrame("shf_1", 18'h00000, 1'b0);
    beatS(8'hDD, 8'hEE); expectFrame("shf_2", 18'h1AABB, 1'b0);
    beatN(8'hFF);        expectFrame("shf_3", 18'h1CCDD, 1'b0);
    beatA(8'h12, 8'h34); expectFrame("shf_4", 18'h3EEFF, 1'b1);
    checkOutput("shf_words", {22'h0, burst_words}, 32'd3);
    checkOutput("shf_slip", {31'h0, slip_err}, 32'h0);
    beatN(8'h00);        expectFrame("b2b_0", 18'h31234, 1'b1);
    checkOutput("b2b_words", {22'h0, burst_words}, 32'd1);

    // Dropping cap_en ends the burst; the following beats start a new one.
    beatA(8'hA1, 8'hA2); expectFrame("cap_0", 18'h00000, 1'b0);
    beatA(8'hA3, 8'hA4); expectFrame("cap_1", 18'h1A1A2, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'hA5, 8'hA6);
    expectFrame("cap_2", 18'h3A3A4, 1'b1);
    checkOutput("cap_words0", {22'h0, burst_words}, 32'd2);
    beatA(8'hA7, 8'hA8); expectFrame("cap_3", 18'h00000, 1'b0);
    beatA(8'hA9, 8'hAA); expectFrame("cap_4", 18'h1A7A8, 1'b0);
    beatN(8'h00);        expectFrame("cap_5", 18'h3A9AA, 1'b1);
    checkOutput("cap_words1", {22'h0, burst_words}, 32'd2);

    // Phase slip: the shifted beat closes the burst and latches slip_err.
    beatA(8'h11, 8'h22); expectFrame("slip_0", 18'h00000, 1'b0);
    beatA(8'h33, 8'h44); expectFrame("slip_1", 18'h11122, 1'b0);
    beatS(8'h55, 8'h66); expectFrame("slip_2", 18'h33344, 1'b1);
    checkOutput("slip_words", {22'h0, burst_words}, 32'd2);
    checkOutput("slip_set", {31'h0, slip_err}, 32'h1);
    beatA(8'h77, 8'h88); expectFrame("slip_3", 18'h00000, 1'b0);
    beatN(8'h00);        expectFrame("slip_4", 18'h37788, 1'b1);
    checkOutput("slip_sticky", {31'h0, slip_err}, 32'h1);

    // Shifted-mode slip with nothing staged: no frame, but the error latches.
    beatS(8'h00, 8'h99); expectFrame("sslip_0", 18'h00000, 1'b0);
    beatA(8'h01, 8'h02); expectFrame("sslip_1", 18'h00000, 1'b0);
    checkOutput("sslip_slip", {31'h0, slip_err_sat}, 32'h1);

    // Twenty-word burst saturates the 4-bit counter, then a two-word burst follows.
    for (int i = 0; i < 20; i++) begin
      b = 8'(i);
      beatA(b, b + 8'h40);
      if (i > 0)
        checkOutput("sat_stream", {14'h0, dout}, {14'h0, 2'b01, b - 8'h01, b + 8'h3F});
      else
        checkOutput("sat_stream0", {14'h0, dout}, 32'h0);
    end
    beatN(8'h00); expectFrame("sat_end", 18'h31353, 1'b1);
    checkOutput("sat_words10", {22'h0, burst_words}, 32'd20);
    checkOutput("sat_words4", {28'h0, burst_words_sat}, 32'd15);
    checkOutput("sat_done4", {31'h0, burst_done_sat}, 32'h1);
    beatA(8'hC1, 8'hC2); expectFrame("sat_b2b0", 18'h00000, 1'b0);
    beatA(8'hC3, 8'hC4); expectFrame("sat_b2b1", 18'h1C1C2, 1'b0);
    beatN(8'h00);        expectFrame("sat_b2b2", 18'h3C3C4, 1'b1);
    checkOutput("sat_b2b_words4", {28'h0, burst_words_sat}, 32'd2);
    checkOutput("sat_b2b_words10", {22'h0, burst_words}, 32'd2);
    beatN(8'h00);        expectFrame("sat_idle", 18'h00000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
